// File: rtl/flt_add_sched.sv
// flt_add_sched
// Round-robin scheduler sharing one multi-cycle half-precision float adder
// among NREQ requesters. Exactly one request is in flight at a time.
// Zero operands and sign mismatches are answered without the adder. The
// adder start/done handshake is guarded by a timeout. All outputs are decoded
// from registered state, so there is no combinational input-to-output path.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req_valid[NREQ]   request pending per requester (held until req_ready)
//   req_a/req_b       16-bit operands per requester, slice i = [16i+15:16i]
//   req_ready[NREQ]   one-hot pulse: request of requester i accepted
//   rsp_valid[NREQ]   one-hot pulse: response for requester i
//   rsp_sum, rsp_err  result and error flag, meaningful only with rsp_valid
//   fu_start          one-cycle adder start pulse
//   fu_a, fu_b        adder operands, stable from ISSUE until WAIT is left
//   fu_done, fu_sum   adder completion and result (looked at only in WAIT)
//   busy              high in every state except IDLE
module flt_add_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_err,
    output logic                 fu_start,
    output logic [15:0]          fu_a,
    output logic [15:0]          fu_b,
    input  logic                 fu_done,
    input  logic [15:0]          fu_sum,
    output logic                 busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BYPASS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant;
    logic [15:0]     op_a, op_b;
    logic [15:0]     result;
    logic            err;
    logic [CW-1:0]   wait_cnt;

    // Operand slices as arrays so the granted requester can be indexed.
    logic [15:0]     a_arr [NREQ];
    logic [15:0]     b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[16*i +: 16];
        assign b_arr[i] = req_b[16*i +: 16];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first set req_valid bit at or after rr_ptr.
    // ------------------------------------------------------------------
    logic            found;
    logic [GW-1:0]   pick;
    int              idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification of the picked operands (exponent 0 means zero).
    // ------------------------------------------------------------------
    logic [15:0]     sel_a, sel_b;
    logic            cls_bypass;
    logic            cls_err;
    logic [15:0]     cls_result;

    assign sel_a = a_arr[pick];
    assign sel_b = b_arr[pick];

    always_comb begin
        cls_bypass = 1'b1;
        cls_err    = 1'b0;
        cls_result = 16'h0000;
        if (sel_a[14:10] == 5'd0) begin
            cls_result = sel_b;
        end else if (sel_b[14:10] == 5'd0) begin
            cls_result = sel_a;
        end else if (sel_a[15] != sel_b[15]) begin
            // Subtraction is not supported by the shared adder.
            cls_err = 1'b1;
        end else begin
            cls_bypass = 1'b0;
        end
    end

    logic wait_expired;
    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (found) state_nxt = cls_bypass ? S_BYPASS : S_ISSUE;
            S_ISSUE:  state_nxt = S_WAIT;
            S_BYPASS: state_nxt = S_RESP;
            S_WAIT:   if (fu_done || wait_expired) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand registers drive fu_a/fu_b directly, so they are
            // reset too; otherwise the adder inputs would be X after reset.
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            op_a     <= 16'h0000;
            op_b     <= 16'h0000;
            result   <= 16'h0000;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant  <= pick;
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        result <= cls_result;
                        err    <= cls_err;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A completion wins over a timeout in the same cycle.
                    if (fu_done) begin
                        result <= fu_sum;
                        err    <= 1'b0;
                    end else if (wait_expired) begin
                        result <= 16'h0000;
                        err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] grant_oh;
    assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;

    assign req_ready = (state == S_ISSUE || state == S_BYPASS) ? grant_oh : '0;
    assign rsp_valid = (state == S_RESP) ? grant_oh : '0;
    assign rsp_sum   = (state == S_RESP) ? result : 16'h0000;
    assign rsp_err   = (state == S_RESP) && err;
    assign fu_start  = (state == S_ISSUE);
    assign fu_a      = op_a;
    assign fu_b      = op_b;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_flt_add_sched.sv
// tb_flt_add_sched
// Self-checking bench for flt_add_sched: a table of single-requester
// transactions with hand-computed results, hand-written sequences for reset,
// stale completion and round-robin order, then randomized traffic checked
// against a transaction-level reference model.
module tb_flt_add_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = 120;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_a = '0;
    logic [16*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_sum;
    logic                 rsp_err;
    logic                 fu_start;
    logic [15:0]          fu_a, fu_b;
    logic                 fu_done;
    logic [15:0]          fu_sum;
    logic                 busy;

    flt_add_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .fu_start  (fu_start),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_done   (fu_done),
        .fu_sum    (fu_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int model_rr    = 0;   // reference round-robin pointer
    int fu_lat      = 1;   // adder latency in WAIT cycles; 0 = never done

    logic        model_done = 1'b0;
    logic [15:0] model_sum  = 16'h0000;
    logic        late_done  = 1'b0;

    assign fu_done = model_done | late_done;
    assign fu_sum  = model_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Same-sign half-float add (truncating); stands in for the real adder.
    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [4:0]  ex;
        logic [11:0] mx, my, s;
        int          d;
        if (a[14:10] >= b[14:10]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = x[14:10];
        mx = {2'b01, x[9:0]};
        my = {2'b01, y[9:0]};
        d  = int'(x[14:10]) - int'(y[14:10]);
        my = (d > 11) ? 12'd0 : my >> d;
        s  = mx + my;
        if (s[11]) begin
            s  = s >> 1;
            ex = ex + 5'd1;
        end
        return {x[15], ex, s[9:0]};
    endfunction

    // Adder model: completes fu_lat WAIT cycles after seeing fu_start.
    initial begin
        forever begin
            @(negedge clk);
            if (fu_start === 1'b1 && fu_lat > 0) begin
                automatic int          l = fu_lat;
                automatic logic [15:0] s = fadd(fu_a, fu_b);
                repeat (l) @(negedge clk);
                model_done = 1'b1;
                model_sum  = s;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // One transaction from the IDLE state; every timing is relative to the
    // cycle T in which req_valid is presented.
    task automatic do_txn(input string tag, input logic [NREQ-1:0] mask,
                          input logic [16*NREQ-1:0] av, input logic [16*NREQ-1:0] bv,
                          input int lat, input int exp_g, input logic [15:0] exp_sum,
                          input logic exp_err, input int exp_off, input int exp_fu);
        int nready, nfu;
        logic got;
        nready = 0;
        nfu    = 0;
        got    = 1'b0;
        fu_lat = lat;
        @(negedge clk);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        req_a     = av;
        req_b     = bv;
        req_valid = mask;
        for (int cyc = 1; cyc <= MAXC; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                nready++;
                check({tag, ".ready"}, 32'(req_ready), 32'(onehot(exp_g)));
                check({tag, ".ready_cyc"}, cyc, 1);
                req_valid = '0;
            end
            if (fu_start) nfu++;
            if (rsp_valid != '0) begin
                check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(onehot(exp_g)));
                check({tag, ".rsp_cyc"}, cyc, exp_off);
                check({tag, ".rsp_sum"}, 32'(rsp_sum), 32'(exp_sum));
                check({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
                got = 1'b1;
                break;
            end
        end
        req_valid = '0;
        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        check({tag, ".ready_cnt"}, nready, 1);
        check({tag, ".fu_starts"}, nfu, exp_fu);
        model_rr = (exp_g + 1) % NREQ;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rr = 0;
    endtask

    typedef struct {
        int          r;
        logic [15:0] a, b;
        int          lat;
        logic [15:0] sum;
        logic        err;
        int          off;
        int          fu;
    } vec_t;

    vec_t tbl [9];

    initial begin : fatal_watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*NREQ-1:0] av, bv;

        //          r  a         b         lat sum       err off fu
        tbl[0] = '{0, 16'h3C00, 16'h3C00, 2,  16'h4000, 0,  4,  1};
        tbl[1] = '{1, 16'h0000, 16'h3C00, 1,  16'h3C00, 0,  2,  0};
        tbl[2] = '{1, 16'h4000, 16'h0000, 1,  16'h4000, 0,  2,  0};
        tbl[3] = '{2, 16'h3C00, 16'hBC00, 1,  16'h0000, 1,  2,  0};
        tbl[4] = '{3, 16'h4000, 16'h3C00, 1,  16'h4200, 0,  3,  1};
        tbl[5] = '{0, 16'h0000, 16'h8000, 1,  16'h8000, 0,  2,  0};
        tbl[6] = '{2, 16'hBC00, 16'hBC00, 1,  16'hC000, 0,  3,  1};
        tbl[7] = '{1, 16'h3C00, 16'h3C00, 64, 16'h4000, 0,  66, 1};
        tbl[8] = '{3, 16'h3C00, 16'h3C00, 0,  16'h0000, 1,  66, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_sum",   32'(rsp_sum),   32'd0);
        check("rst.rsp_err",   32'(rsp_err),   32'd0);
        check("rst.fu_start",  32'(fu_start),  32'd0);
        check("rst.fu_a",      32'(fu_a),      32'd0);
        check("rst.fu_b",      32'(fu_b),      32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        reset = 1'b0;
        model_rr = 0;

        // Table of single-requester transactions; other slices carry junk.
        for (int i = 0; i < 9; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            av[16*tbl[i].r +: 16] = tbl[i].a;
            bv[16*tbl[i].r +: 16] = tbl[i].b;
            do_txn($sformatf("vec%0d", i), onehot(tbl[i].r), av, bv, tbl[i].lat,
                   tbl[i].r, tbl[i].sum, tbl[i].err, tbl[i].off, tbl[i].fu);
        end

        // Stale completion after the timeout above must be ignored.
        @(negedge clk);
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("late_done.rsp_valid", 32'(rsp_valid), 32'd0);
            check("late_done.busy", 32'(busy), 32'd0);
        end

        // Reset in the 3rd WAIT cycle of a transaction that never completes.
        fu_lat = 0;
        @(negedge clk);
        req_a[15:0] = 16'h3C00;
        req_b[15:0] = 16'h3C00;
        req_valid   = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("rstwait.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rstwait.req_ready", 32'(req_ready), 32'd0);
        check("rstwait.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstwait.rsp_sum",   32'(rsp_sum),   32'd0);
        check("rstwait.rsp_err",   32'(rsp_err),   32'd0);
        check("rstwait.fu_start",  32'(fu_start),  32'd0);
        check("rstwait.fu_a",      32'(fu_a),      32'd0);
        check("rstwait.busy",      32'(busy),      32'd0);
        reset = 1'b0;
        model_rr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstwait.no_rsp", 32'(rsp_valid), 32'd0);
        end
        // Requesters 1 and 3 both pending right after reset: pointer 0 picks 1.
        av = {16'h4400, 16'h1111, 16'h4000, 16'h2222};
        bv = {16'h3C00, 16'h3333, 16'h0000, 16'h4444};
        do_txn("post_rst_rr", 4'b1010, av, bv, 1, 1, 16'h4000, 0, 2, 0);
        av[63:48] = 16'h4400;
        bv[63:48] = 16'h3C00;
        do_txn("post_rst_r3", 4'b1000, av, bv, 3, 3, 16'h4500, 0, 5, 1);

        // Round robin: all requesters hold req_valid, 1-cycle adder.
        apply_reset();
        begin
            int          order [5] = '{0, 1, 2, 3, 0};
            logic [15:0] sums  [4] = '{16'h4000, 16'h4200, 16'h4800, 16'h3C00};
            int ng, nr, last;
            ng = 0; nr = 0; last = 0;
            fu_lat = 1;
            @(negedge clk);
            req_a = {16'h3800, 16'h4400, 16'h4000, 16'h3C00};
            req_b = {16'h3800, 16'h4400, 16'h3C00, 16'h3C00};
            req_valid = 4'b1111;
            for (int cyc = 1; cyc <= 40 && nr < 5; cyc++) begin
                @(negedge clk);
                if (req_ready != '0 && ng < 5) begin
                    check($sformatf("rr.grant%0d", ng), 32'(req_ready), 32'(onehot(order[ng])));
                    if (ng > 0) check($sformatf("rr.interval%0d", ng), cyc - last, 4);
                    last = cyc;
                    ng++;
                    if (ng == 5) req_valid = '0;
                end
                if (rsp_valid != '0 && nr < 5) begin
                    check($sformatf("rr.rsp%0d", nr), 32'(rsp_valid), 32'(onehot(order[nr])));
                    check($sformatf("rr.sum%0d", nr), 32'(rsp_sum), 32'(sums[order[nr]]));
                    nr++;
                end
            end
            req_valid = '0;
            check("rr.responses", nr, 5);
            model_rr = 1;
        end

        // Randomized traffic against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            logic [NREQ-1:0] mask;
            logic [15:0] a, b, es;
            logic ee;
            int g, lat, off, fu;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if ($urandom_range(0, 5) == 0) a[14:10] = 5'd0;
                if ($urandom_range(0, 5) == 0) b[14:10] = 5'd0;
                if ($urandom_range(0, 3) != 0) b[15] = a[15];
                av[16*i +: 16] = a;
                bv[16*i +: 16] = b;
            end
            lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mask[(model_rr + k) % NREQ]) g = (model_rr + k) % NREQ;
            a = av[16*g +: 16];
            b = bv[16*g +: 16];
            fu = 0; ee = 1'b0; off = 2;
            if (a[14:10] == 0)      es = b;
            else if (b[14:10] == 0) es = a;
            else if (a[15] != b[15]) begin es = 16'h0000; ee = 1'b1; end
            else begin
                fu = 1;
                if (lat == 0) begin es = 16'h0000; ee = 1'b1; off = 2 + TIMEOUT; end
                else begin es = fadd(a, b); off = 2 + lat; end
            end
            do_txn($sformatf("rand%0d", t), mask, av, bv, lat, g, es, ee, off, fu);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flt_add_sched.md
# flt_add_sched

Round-robin scheduler that shares one multi-cycle half-width float adder (1 sign, 5 exponent, 10 mantissa bits; hidden bit implied; exponent 0 means zero) among NREQ requesters. It grants one request at a time, handles trivial cases without using the adder, sequences the adder's start/done handshake with a timeout, and returns the sum to the granted requester. It sits between the requester ports and the single float-add datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, maximum WAIT cycles before an error response (≥2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request pending per requester; held until req_ready
- req_a  in  16*NREQ  operand A per requester, slice i = [16i+15:16i]
- req_b  in  16*NREQ  operand B per requester
- req_ready  out  NREQ  one-hot, one-cycle pulse: request i accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: response for requester i
- rsp_sum  out  16  result; valid only while rsp_valid is nonzero
- rsp_err  out  1  error flag; valid only while rsp_valid is nonzero
- fu_start  out  1  one-cycle adder start pulse
- fu_a, fu_b  out  16  operands to adder; stable from ISSUE until leaving WAIT
- fu_done  in  1  adder completion, sampled only in WAIT
- fu_sum  in  16  adder result, valid when fu_done=1
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, BYPASS, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant g = the first set bit at or after rr_ptr (wrapping modulo NREQ).
  - Latch req_a[g] into op_a and req_b[g] into op_b; record g.
  - Classify the latched operands:
    - exp(op_a)==0: result op_b, go to BYPASS.
    - else exp(op_b)==0: result op_a, go to BYPASS.
    - else sign(op_a)!=sign(op_b): error, result 0x0000, go to BYPASS. Subtraction is unsupported.
    - else go to ISSUE.
- ISSUE:
  - fu_start=1, fu_a=op_a, fu_b=op_b, req_ready[g]=1.
  - Clear the WAIT counter; next state is WAIT.
- BYPASS:
  - req_ready[g]=1; the adder is not touched (fu_start=0).
  - Next state is RESP with the result and error flag from the IDLE classification.
- WAIT:
  - If fu_done=1, latch fu_sum with err=0 and go to RESP.
  - Else, if counter==TIMEOUT-1, set result 0x0000, err=1 and go to RESP.
  - Else increment the counter.
  - fu_done has priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid[g]=1 with rsp_sum and rsp_err.
  - rr_ptr ← (g+1) mod NREQ; next state is IDLE.
- rr_ptr updates only in RESP.
- req_valid and operands of non-granted requesters are ignored until they are granted.
- A requester that holds req_valid high after its req_ready is treated as issuing a new request.
- fu_done outside WAIT is ignored, including stale dones after a timeout.
- No requests are accepted while busy; there is no queueing.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, counter=0.
  - req_ready=0, rsp_valid=0, rsp_sum=0, rsp_err=0.
  - fu_start=0, fu_a=0, fu_b=0, busy=0.
- All outputs are registered or decoded from the registered state; there are no combinational input-to-output paths.
- Let cycle T be the IDLE cycle where req_valid is sampled.
- Adder path:
  - T+1: ISSUE (req_ready, fu_start).
  - T+2: first WAIT cycle.
  - If fu_done is sampled in the k-th WAIT cycle (k≥1), rsp_valid is high in cycle T+2+k.
  - Minimum latency to response is 3 cycles.
- Bypass path: T+1 BYPASS, T+2 RESP.
- Timeout path: the response is in cycle T+2+TIMEOUT.
- Back-to-back requests: the earliest next grant is sampled in the IDLE cycle right after RESP. Throughput with a 1-cycle adder is one transaction per 4 cycles.
- Reset mid-operation (any state):
  - Next cycle is IDLE with reset values.
  - No rsp_valid is issued for the aborted transaction; fu_start drops immediately.

## Test plan
- 1.0+1.0: requester 0 sends 0x3C00+0x3C00; adder model returns done after 2 cycles with 0x4000. Required: req_ready[0] at T+1, one fu_start pulse, rsp_valid[0] with rsp_sum 0x4000 and rsp_err=0 at T+4.
- Zero bypass: requester 1 sends 0x0000+0x3C00 → rsp_sum 0x3C00, err=0, rsp_valid[1] at T+2, fu_start never asserted. 0x4000+0x0000 → 0x4000.
- Sign mismatch: requester 2 sends 0x3C00+0xBC00 → rsp_err=1, rsp_sum 0x0000 at T+2, no fu_start.
- Round robin: all four requesters hold req_valid continuously, adder done in 1 cycle. Required grant order is 0,1,2,3,0, each response routed to the matching rsp_valid bit with the correct sum.
- Timeout: fu_done is never asserted with TIMEOUT=64 → rsp_err=1 at T+66, then return to IDLE. A late fu_done pulse afterwards produces no response.
- Reset during WAIT: assert reset in the 3rd WAIT cycle → all outputs at reset values next cycle, no rsp_valid, rr_ptr=0. A subsequent request from requester 3 is served normally.
